// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if
//   Bundles the three buses around the instruction sequencer:
//   - instruction handshake from decode: instr_valid/instr_ready plus the
//     decoded fields cond, op, s, wb, rn, rm and rd.
//   - register-file ports: two combinational read ports and one write port.
//   - ALU ports: operands, op and flag-enable out; result and flags back.
//   Modports:
//     master - the sequencer (alu_seq_ctrl)
//     slave  - its surroundings: the decode stage, register file and ALU
interface alu_seq_ctrl_if;
    // Instruction handshake
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_cond;
    logic [3:0]  instr_op;
    logic        instr_s;
    logic        instr_wb;
    logic [3:0]  instr_rn;
    logic [3:0]  instr_rm;
    logic [3:0]  instr_rd;

    // Register file
    logic [3:0]  rf_ra_addr;
    logic [3:0]  rf_rb_addr;
    logic [31:0] rf_ra_data;
    logic [31:0] rf_rb_data;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;

    // ALU
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic        alu_s;
    logic        alu_c;
    logic        alu_v;
    logic        alu_shift_cout;
    logic [31:0] alu_f;
    logic [3:0]  alu_nzcv;

    modport master (
        input  instr_valid, instr_cond, instr_op, instr_s, instr_wb,
               instr_rn, instr_rm, instr_rd,
        output instr_ready,
        output rf_ra_addr, rf_rb_addr, rf_we, rf_wa, rf_wd,
        input  rf_ra_data, rf_rb_data,
        output alu_a, alu_b, alu_op, alu_s, alu_c, alu_v, alu_shift_cout,
        input  alu_f, alu_nzcv
    );

    modport slave (
        output instr_valid, instr_cond, instr_op, instr_s, instr_wb,
               instr_rn, instr_rm, instr_rd,
        input  instr_ready,
        input  rf_ra_addr, rf_rb_addr, rf_we, rf_wa, rf_wd,
        output rf_ra_data, rf_rb_data,
        input  alu_a, alu_b, alu_op, alu_s, alu_c, alu_v, alu_shift_cout,
        output alu_f, alu_nzcv
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
//   Multi-cycle sequencer that runs one decoded data-processing instruction
//   at a time on the 32-bit ALU. It checks the instruction's condition code
//   against the architectural NZCV register, reads two operands, drives the
//   ALU, writes the result back, and commits the ALU flags when S is set.
//   This block is the sole owner of NZCV.
//
//   Ports:
//     clk        system clock, rising edge
//     rst        asynchronous, active-high reset
//     bus        alu_seq_ctrl_if.master: instruction handshake, register file
//                and ALU buses
//     nzcv       architectural flags {N,Z,C,V}
//     busy       high in any state other than IDLE
//     done       one-cycle pulse in WB: instruction executed and committed
//     skipped    one-cycle pulse in SKIP: instruction squashed
//     dbg_state  current FSM state encoding, for observation only
//
//   Handshake: an instruction transfers on a rising edge where instr_valid
//   and instr_ready are both high. instr_ready is high only in IDLE and does
//   not depend on instr_valid. All instr_* fields are sampled on that edge
//   only. instr_valid is ignored while busy.
module alu_seq_ctrl (
    input  logic           clk,
    input  logic           rst,
    alu_seq_ctrl_if.master bus,
    output logic [3:0]     nzcv,
    output logic           busy,
    output logic           done,
    output logic           skipped,
    output logic [2:0]     dbg_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        EXEC = 3'd2,
        WB   = 3'd3,
        SKIP = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;

    // Latched instruction fields
    logic [3:0]  op_q;
    logic [3:0]  rn_q;
    logic [3:0]  rm_q;
    logic [3:0]  rd_q;
    logic        s_q;
    logic        wb_q;

    // Operand, result and flag registers
    logic [31:0] opa_q;
    logic [31:0] opb_q;
    logic [31:0] res_q;
    logic [3:0]  flags_q;

    // Last values driven while active, so each output holds when its state is left
    logic [3:0]  ra_hold;
    logic [3:0]  rb_hold;
    logic [3:0]  op_hold;
    logic [3:0]  wa_hold;

    logic        accept;

    // ARM condition check against flags {N,Z,C,V}
    function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        logic pass;
        {n, z, c, v} = f;
        case (cc)
            4'h0:    pass = z;
            4'h1:    pass = !z;
            4'h2:    pass = c;
            4'h3:    pass = !c;
            4'h4:    pass = n;
            4'h5:    pass = !n;
            4'h6:    pass = v;
            4'h7:    pass = !v;
            4'h8:    pass = c && !z;
            4'h9:    pass = !c || z;
            4'hA:    pass = (n == v);
            4'hB:    pass = (n != v);
            4'hC:    pass = !z && (n == v);
            4'hD:    pass = z || (n != v);
            4'hE:    pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

    function automatic logic op_legal(input logic [3:0] op);
        return (op != 4'h9) && (op != 4'hB);
    endfunction

    assign accept = (state == IDLE) && bus.instr_valid;

    // State register and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            nzcv    <= 4'b0000;
            op_q    <= 4'h0;
            rn_q    <= 4'h0;
            rm_q    <= 4'h0;
            rd_q    <= 4'h0;
            s_q     <= 1'b0;
            wb_q    <= 1'b0;
            opa_q   <= 32'h0;
            opb_q   <= 32'h0;
            res_q   <= 32'h0;
            flags_q <= 4'h0;
            ra_hold <= 4'h0;
            rb_hold <= 4'h0;
            op_hold <= 4'h0;
            wa_hold <= 4'h0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q <= bus.instr_op;
                rn_q <= bus.instr_rn;
                rm_q <= bus.instr_rm;
                rd_q <= bus.instr_rd;
                s_q  <= bus.instr_s;
                wb_q <= bus.instr_wb;
            end
            if (state == READ) begin
                opa_q   <= bus.rf_ra_data;
                opb_q   <= bus.rf_rb_data;
                ra_hold <= rn_q;
                rb_hold <= rm_q;
            end
            if (state == EXEC) begin
                res_q   <= bus.alu_f;
                flags_q <= bus.alu_nzcv;
                op_hold <= op_q;
            end
            if (state == WB) begin
                wa_hold <= rd_q;
                // Committed at the edge leaving WB, so an instruction accepted
                // in the following IDLE cycle already sees the new flags.
                if (s_q) begin
                    nzcv <= flags_q;
                end
            end
        end
    end

    // Next-state and control outputs
    always_comb begin
        state_next      = state;
        bus.instr_ready = 1'b0;
        busy            = 1'b1;
        done            = 1'b0;
        skipped         = 1'b0;
        bus.rf_we       = 1'b0;
        bus.alu_s       = 1'b0;
        bus.rf_ra_addr  = ra_hold;
        bus.rf_rb_addr  = rb_hold;
        bus.alu_op      = op_hold;
        bus.rf_wa       = wa_hold;
        case (state)
            IDLE: begin
                bus.instr_ready = 1'b1;
                busy            = 1'b0;
                if (bus.instr_valid) begin
                    if (cond_pass(bus.instr_cond, nzcv) && op_legal(bus.instr_op)) begin
                        state_next = READ;
                    end else begin
                        state_next = SKIP;
                    end
                end
            end
            READ: begin
                bus.rf_ra_addr = rn_q;
                bus.rf_rb_addr = rm_q;
                state_next     = EXEC;
            end
            EXEC: begin
                bus.alu_op = op_q;
                bus.alu_s  = s_q;
                state_next = WB;
            end
            WB: begin
                bus.rf_we  = wb_q;
                bus.rf_wa  = rd_q;
                done       = 1'b1;
                state_next = IDLE;
            end
            SKIP: begin
                skipped    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand and result registers only change at the end of READ and EXEC,
    // so driving them directly gives both the active value and the hold.
    assign bus.alu_a          = opa_q;
    assign bus.alu_b          = opb_q;
    assign bus.rf_wd          = res_q;
    assign bus.alu_c          = nzcv[1];
    assign bus.alu_v          = nzcv[0];
    assign bus.alu_shift_cout = nzcv[1];
    assign dbg_state          = state;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] nzcv;
    logic       busy, done, skipped;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    alu_seq_ctrl_if bus ();

    alu_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.master),
        .nzcv      (nzcv),
        .busy      (busy),
        .done      (done),
        .skipped   (skipped),
        .dbg_state (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // ---------------- environment: ALU and register file ----------------
    // Op map: 0 AND, 1 EOR, 2 SUB, 3 RSB, 4 ADD, 5 ADC, 6 SBC, 7 RSC, 8 TST,
    // A CMN, C ORR, D MOV, E BIC, F MVN. Returns {N,Z,C,V, result}.
    function automatic logic [35:0] alu_calc(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic ci, input logic vi);
        logic [32:0] sum;
        logic [31:0] x, y, f;
        logic        cin, arith, c, v;
        arith = 1'b1; x = a; y = b; cin = 1'b0;
        case (op)
            4'h2: begin y = ~b; cin = 1'b1; end
            4'h3: begin x = b; y = ~a; cin = 1'b1; end
            4'h4, 4'hA: cin = 1'b0;
            4'h5: cin = ci;
            4'h6: begin y = ~b; cin = ci; end
            4'h7: begin x = b; y = ~a; cin = ci; end
            default: arith = 1'b0;
        endcase
        sum = {1'b0, x} + {1'b0, y} + {32'b0, cin};
        if (arith) begin
            f = sum[31:0];
            c = sum[32];
            v = (x[31] == y[31]) && (f[31] != x[31]);
        end else begin
            case (op)
                4'h0, 4'h8: f = a & b;
                4'h1:       f = a ^ b;
                4'hC:       f = a | b;
                4'hD:       f = b;
                4'hE:       f = a & ~b;
                4'hF:       f = ~b;
                default:    f = 32'h0;
            endcase
            c = ci;
            v = vi;
        end
        return {f[31], (f == 32'h0), c, v, f};
    endfunction

    logic [31:0] tb_rf [16];

    assign bus.rf_ra_data = tb_rf[bus.rf_ra_addr];
    assign bus.rf_rb_data = tb_rf[bus.rf_rb_addr];
    always_comb begin
        {bus.alu_nzcv, bus.alu_f} = alu_calc(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_c, bus.alu_v);
    end

    always @(posedge clk) begin
        if (bus.rf_we) tb_rf[bus.rf_wa] <= bus.rf_wd;
    end

    // ---------------- reference model ----------------
    // One record per expected cycle after an accept; an empty queue means idle.
    typedef struct {
        logic        ready, busy, done, skipped, we, alu_s, upd, chk_rd, chk_ex;
        logic [3:0]  wa, ra, rb, op, flags;
        logic [31:0] wd, a, b;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_rf [16];
    logic [3:0]  m_nzcv = 4'b0000;
    int          m_accepts = 0;
    int          done_cnt = 0;

    function automatic exp_t blank_rec(input logic is_busy);
        exp_t r;
        r = '{default: '0};
        r.busy  = is_busy;
        r.ready = !is_busy;
        return r;
    endfunction

    // Base test on cond[3:1], odd codes invert it; 14 always, 15 never.
    function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v, base;
        {n, z, c, v} = f;
        case (cc[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (cc == 4'hF) return 1'b0;
        if (cc == 4'hE) return 1'b1;
        return cc[0] ? !base : base;
    endfunction

    always @(posedge clk or posedge rst) begin
        exp_t        e, r0, r1, r2;
        logic [35:0] res;
        if (rst) begin
            exp_q.delete();
            m_nzcv = 4'b0000;
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.upd) m_nzcv = e.flags;
            if (e.we)  m_rf[e.wa] = e.wd;
        end else if (bus.instr_valid) begin
            m_accepts++;
            if (cond_ok(bus.instr_cond, m_nzcv) && bus.instr_op != 4'h9 && bus.instr_op != 4'hB) begin
                r0 = blank_rec(1'b1);
                r0.chk_rd = 1'b1; r0.ra = bus.instr_rn; r0.rb = bus.instr_rm;
                r1 = blank_rec(1'b1);
                r1.chk_ex = 1'b1; r1.op = bus.instr_op; r1.alu_s = bus.instr_s;
                r1.a = m_rf[bus.instr_rn]; r1.b = m_rf[bus.instr_rm];
                res = alu_calc(bus.instr_op, r1.a, r1.b, m_nzcv[1], m_nzcv[0]);
                r2 = blank_rec(1'b1);
                r2.done = 1'b1; r2.we = bus.instr_wb; r2.wa = bus.instr_rd; r2.wd = res[31:0];
                r2.upd = bus.instr_s; r2.flags = res[35:32];
                exp_q.push_back(r0);
                exp_q.push_back(r1);
                exp_q.push_back(r2);
            end else begin
                r0 = blank_rec(1'b1);
                r0.skipped = 1'b1;
                exp_q.push_back(r0);
            end
        end
    end

    // ---------------- scoreboard compare, every cycle ----------------
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            e = (exp_q.size() > 0) ? exp_q[0] : blank_rec(1'b0);
            if (done) done_cnt++;
            check("ctrl", 72'({bus.instr_ready, busy, done, skipped, bus.rf_we, bus.alu_s}),
                  72'({e.ready, e.busy, e.done, e.skipped, e.we, e.alu_s}));
            check("flags", 72'({nzcv, bus.alu_c, bus.alu_v, bus.alu_shift_cout}),
                  72'({m_nzcv, m_nzcv[1], m_nzcv[0], m_nzcv[1]}));
            if (e.we)     check("wb", 72'({bus.rf_wa, bus.rf_wd}), 72'({e.wa, e.wd}));
            if (e.chk_rd) check("read_addr", 72'({bus.rf_ra_addr, bus.rf_rb_addr}), 72'({e.ra, e.rb}));
            if (e.chk_ex) check("exec", 72'({bus.alu_op, bus.alu_a, bus.alu_b}), 72'({e.op, e.a, e.b}));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_fields(input logic [3:0] cond, input logic [3:0] op, input logic s,
                              input logic wb, input logic [3:0] rn, input logic [3:0] rm,
                              input logic [3:0] rd);
        bus.instr_cond = cond; bus.instr_op = op; bus.instr_s = s; bus.instr_wb = wb;
        bus.instr_rn = rn; bus.instr_rm = rm; bus.instr_rd = rd;
    endtask

    // Offers one instruction, then returns at the negedge where done or skipped
    // is seen; lat counts cycles after the accept (1 = first cycle).
    task automatic issue(input logic [3:0] cond, input logic [3:0] op, input logic s,
                         input logic wb, input logic [3:0] rn, input logic [3:0] rm,
                         input logic [3:0] rd, output int lat);
        int acc0;
        lat = 0;
        @(negedge clk);
        set_fields(cond, op, s, wb, rn, rm, rd);
        bus.instr_valid = 1'b1;
        acc0 = m_accepts;
        for (int i = 0; i < 20 && m_accepts == acc0; i++) @(negedge clk);
        bus.instr_valid = 1'b0;
        if (m_accepts == acc0) begin
            check("accept_timeout", 72'(0), 72'(1));
        end else begin
            for (int i = 1; i <= 10; i++) begin
                if (done || skipped) begin
                    lat = i;
                    break;
                end
                @(negedge clk);
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int d0;
        bus.instr_valid = 1'b0;
        set_fields(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 16; i++) tb_rf[i] = $urandom;
        tb_rf[1] = 32'd5;         tb_rf[2] = 32'd7;
        tb_rf[3] = 32'h0;         tb_rf[4] = 32'h8000_0000;
        tb_rf[5] = 32'h8000_0000; tb_rf[6] = 32'hDEAD_BEEF;
        tb_rf[7] = 32'h0;         tb_rf[8] = 32'h0000_0808;
        tb_rf[9] = 32'h0;         tb_rf[10] = 32'h1010_1010;
        tb_rf[11] = 32'h1111_1111;
        for (int i = 0; i < 16; i++) m_rf[i] = tb_rf[i];

        repeat (3) @(negedge clk);
        check("reset_ctrl", 72'({bus.instr_ready, busy, done, skipped, bus.rf_we, bus.alu_s, nzcv}),
              72'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000}));
        check("reset_regs", 72'({bus.alu_a, bus.rf_wd}), 72'(0));
        #1 rst = 1'b0;

        // ADD r3 = r1 + r2 with flags
        issue(4'hE, 4'h4, 1'b1, 1'b1, 4'd1, 4'd2, 4'd3, lat);
        check("add_lat", 72'(lat), 72'(3));
        @(negedge clk);
        check("add_r3", 72'(tb_rf[3]), 72'(12));
        check("add_nzcv", 72'(nzcv), 72'(4'b0000));

        // EQ with Z=0 squashes
        issue(4'h0, 4'h4, 1'b0, 1'b1, 4'd1, 4'd2, 4'd8, lat);
        check("skip_lat", 72'(lat), 72'(1));
        @(negedge clk);
        check("skip_r8", 72'(tb_rf[8]), 72'(32'h0000_0808));
        check("skip_nzcv", 72'(nzcv), 72'(4'b0000));

        // SUBS to zero (compare form), then EQ ADD straight after
        issue(4'hE, 4'h2, 1'b1, 1'b0, 4'd4, 4'd5, 4'd6, lat);
        check("sub_lat", 72'(lat), 72'(3));
        issue(4'h0, 4'h4, 1'b0, 1'b1, 4'd1, 4'd2, 4'd7, lat);
        check("dep_lat", 72'(lat), 72'(3));
        @(negedge clk);
        check("sub_nzcv", 72'(nzcv), 72'(4'b0110));
        check("sub_r6", 72'(tb_rf[6]), 72'(32'hDEAD_BEEF));
        check("dep_r7", 72'(tb_rf[7]), 72'(12));

        // Illegal op and never-condition
        issue(4'hE, 4'h9, 1'b1, 1'b1, 4'd1, 4'd2, 4'd11, lat);
        check("illegal_lat", 72'(lat), 72'(1));
        issue(4'hF, 4'h4, 1'b1, 1'b1, 4'd1, 4'd2, 4'd11, lat);
        check("never_lat", 72'(lat), 72'(1));
        @(negedge clk);
        check("skip_r11", 72'(tb_rf[11]), 72'(32'h1111_1111));
        check("skip_keep_nzcv", 72'(nzcv), 72'(4'b0110));

        // Valid held through READ/EXEC/WB is accepted once
        @(negedge clk);
        set_fields(4'hE, 4'h4, 1'b0, 1'b1, 4'd1, 4'd2, 4'd9);
        d0 = done_cnt;
        bus.instr_valid = 1'b1;
        repeat (4) @(negedge clk);
        bus.instr_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("held_valid_once", 72'(done_cnt - d0), 72'(1));
        check("held_r9", 72'(tb_rf[9]), 72'(12));

        // Reset in EXEC aborts the instruction
        set_fields(4'hE, 4'h4, 1'b1, 1'b1, 4'd1, 4'd2, 4'd10);
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check("abort_reset", 72'({nzcv, bus.rf_we, bus.instr_ready, busy}),
                 72'({4'b0000, 1'b0, 1'b1, 1'b0}));
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_r10", 72'(tb_rf[10]), 72'(32'h1010_1010));
        check("abort_nzcv", 72'(nzcv), 72'(4'b0000));

        // Randomized traffic, checked every cycle by the scoreboard
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            bus.instr_valid = ($urandom_range(0, 9) < 6);
            bus.instr_cond  = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            bus.instr_op    = 4'($urandom_range(0, 15));
            bus.instr_s     = 1'($urandom_range(0, 1));
            bus.instr_wb    = ($urandom_range(0, 4) != 0);
            bus.instr_rn    = 4'($urandom_range(0, 15));
            bus.instr_rm    = 4'($urandom_range(0, 15));
            bus.instr_rd    = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        bus.instr_valid = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 16; i++) check("final_rf", 72'(tb_rf[i]), 72'(m_rf[i]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
